// File: rtl/wci_cfg_responder_if.sv
// WCI::OCP request/response group between a WCI initiator (master) and one worker (slave).
// The interface is wiring only: no latency, and backpressure is the worker's SThreadBusy.
interface wci_cfg_responder_if;
    logic [2:0]  MCmd;
    logic        MAddrSpace;
    logic [3:0]  MByteEn;
    logic [19:0] MAddr;
    logic [31:0] MData;
    logic [1:0]  MFlag;
    logic [2:0]  SResp;
    logic [31:0] SData;
    logic        SThreadBusy;
    logic [1:0]  SFlag;

    modport master (
        output MCmd, MAddrSpace, MByteEn, MAddr, MData, MFlag,
        input  SResp, SData, SThreadBusy, SFlag
    );

    modport slave (
        input  MCmd, MAddrSpace, MByteEn, MAddr, MData, MFlag,
        output SResp, SData, SThreadBusy, SFlag
    );
endinterface

// File: rtl/wci_cfg_responder.sv
// WCI worker responder: control-state machine plus a 16-word config file, one request in flight.
// Response RESP_LATENCY cycles after acceptance; SThreadBusy is held from acceptance through the response cycle.
module wci_cfg_responder #(
    parameter int RESP_LATENCY = 1,
    parameter int NREGS        = 16
) (
    input  logic               wciS0_Clk,
    input  logic               wciS0_MReset,
    wci_cfg_responder_if.slave wciS0
);
    localparam logic [2:0] CMD_WR = 3'd1, CMD_RD = 3'd2;
    localparam logic [2:0] RESP_NULL = 3'd0, RESP_DVA = 3'd1, RESP_FAIL = 3'd2, RESP_ERR = 3'd3;
    localparam logic [3:0] STATUS_IDX = 4'(NREGS - 1);

    typedef enum logic [1:0] {PH_IDLE, PH_WAIT, PH_RESP} phase_e;
    typedef enum logic [1:0] {ST_EXISTS = 2'd0, ST_INIT = 2'd1, ST_OPER = 2'd2, ST_SUSP = 2'd3} wstate_e;

    typedef struct packed {
        logic        is_wr;
        logic        space;
        logic [19:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } req_t;

    phase_e                    phase_q, phase_d;
    wstate_e                   wstate_q, wstate_d, nxt;
    logic [2:0]                cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    req_t                      req_q, req_d, live, cur;
    logic [2:0]                sresp_q, sresp_d;
    logic [31:0]               sdata_q, sdata_d;
    logic [NREGS-2:0][31:0]    regs_q, regs_d;
    logic [15:0]               wcnt_q, wcnt_d;
    logic                      attn_q, attn_d;
    logic [1:0]                mflag_q;
    logic                      accept, fire, legal;
    logic [3:0]                word;
    logic [31:0]               status;

    assign live   = '{is_wr: (wciS0.MCmd == CMD_WR), space: wciS0.MAddrSpace, addr: wciS0.MAddr,
                      be: wciS0.MByteEn, data: wciS0.MData};
    assign accept = !busy_q && (wciS0.MCmd == CMD_WR || wciS0.MCmd == CMD_RD);
    // With single-cycle latency the response is launched at the acceptance edge from the live request.
    assign cur    = (RESP_LATENCY == 1) ? live : req_q;
    assign fire   = (RESP_LATENCY == 1) ? accept : (phase_q == PH_WAIT && cnt_q == 3'd1);
    assign status = {wcnt_q, 6'd0, mflag_q, 5'd0, 1'b0, wstate_q};

    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        sresp_d  = RESP_NULL;
        sdata_d  = '0;
        wstate_d = wstate_q;
        regs_d   = regs_q;
        wcnt_d   = wcnt_q;
        attn_d   = attn_q;
        legal    = 1'b0;
        nxt      = wstate_q;
        word     = cur.addr[5:2];

        case (phase_q)
            PH_IDLE: if (accept) begin
                req_d   = live;
                cnt_d   = 3'(RESP_LATENCY - 1);
                phase_d = (RESP_LATENCY == 1) ? PH_RESP : PH_WAIT;
            end
            PH_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) phase_d = PH_RESP;
            end
            default: phase_d = PH_IDLE;
        endcase
        busy_d = (phase_d != PH_IDLE);

        if (fire) begin
            sresp_d = RESP_ERR;
            if (!cur.space) begin
                if (!cur.is_wr && cur.addr[4:2] != 3'd7) begin
                    case (cur.addr[4:2])
                        3'd0: begin legal = (wstate_q == ST_EXISTS); nxt = ST_INIT; end
                        3'd1: begin legal = (wstate_q == ST_INIT || wstate_q == ST_SUSP); nxt = ST_OPER; end
                        3'd2: begin legal = (wstate_q == ST_OPER); nxt = ST_SUSP; end
                        3'd3: begin legal = (wstate_q != ST_EXISTS); nxt = ST_EXISTS; end
                        default: legal = (wstate_q != ST_EXISTS);
                    endcase
                    if (legal) begin
                        sresp_d  = RESP_DVA;
                        sdata_d  = 32'hC0DE4201;
                        wstate_d = nxt;
                        if (cur.addr[4:2] == 3'd0) attn_d = 1'b0;
                    end else begin
                        sresp_d = RESP_FAIL;
                        sdata_d = 32'hC0DE4202;
                    end
                end
            end else if (wstate_q != ST_EXISTS && cur.addr[19:6] == 14'd0) begin
                if (!cur.is_wr) begin
                    sresp_d = RESP_DVA;
                    sdata_d = (word == STATUS_IDX) ? status : regs_q[word];
                end else if (word != STATUS_IDX) begin
                    sresp_d = RESP_DVA;
                    wcnt_d  = wcnt_q + 16'd1;
                    for (int b = 0; b < 4; b++) begin
                        if (cur.be[b]) regs_d[word][8*b +: 8] = cur.data[8*b +: 8];
                    end
                end
            end
            if (sresp_d == RESP_FAIL || sresp_d == RESP_ERR) attn_d = 1'b1;
        end
    end

    always_ff @(posedge wciS0_Clk) begin
        if (wciS0_MReset) begin
            phase_q  <= PH_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            req_q    <= '0;
            sresp_q  <= RESP_NULL;
            sdata_q  <= '0;
            wstate_q <= ST_EXISTS;
            regs_q   <= '0;
            wcnt_q   <= '0;
            attn_q   <= 1'b0;
            mflag_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            req_q    <= req_d;
            sresp_q  <= sresp_d;
            sdata_q  <= sdata_d;
            wstate_q <= wstate_d;
            regs_q   <= regs_d;
            wcnt_q   <= wcnt_d;
            attn_q   <= attn_d;
            mflag_q  <= wciS0.MFlag;
        end
    end

    assign wciS0.SResp       = sresp_q;
    assign wciS0.SData       = sdata_q;
    assign wciS0.SThreadBusy = busy_q;
    assign wciS0.SFlag       = {wstate_q == ST_OPER, attn_q};
endmodule
